// File: rtl/booth_mul_ctrl.sv
// rtl/booth_mul_ctrl.sv - radix-2 Booth 32x32 signed multiply sequencer driving a shared external adder
module booth_mul_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_c32
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_1;
    logic [WIDTH-1:0]   m_reg;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   r;
    logic               ext;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;

    // Subtract has no carry-in available, so A-M is formed as ~(~A+M).
    always_comb begin
        add_a = '0;
        add_b = '0;
        r     = add_sum;
        ext   = a_reg[WIDTH-1];
        if (state == S_ITER) begin
            case ({q_reg[0], q_1})
                2'b01: begin
                    add_a = a_reg;
                    add_b = m_reg;
                    ext   = a_reg[WIDTH-1] ^ m_reg[WIDTH-1] ^ add_c32;
                end
                2'b10: begin
                    add_a = ~a_reg;
                    add_b = m_reg;
                    r     = ~add_sum;
                    ext   = a_reg[WIDTH-1] ^ m_reg[WIDTH-1] ^ add_c32;
                end
                default: begin
                    add_a = a_reg;
                end
            endcase
        end
    end

    assign a_next = {ext, r[WIDTH-1:1]};
    assign q_next = {r[0], q_reg[WIDTH-1:1]};

    assign busy = (state == S_ITER);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        prod_hi <= a_next;
                        prod_lo <= q_next;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
